iob_gpio_event_latch: RTL and testbench
=======================================

Name: iob_gpio_event_latch

Overview:
- Multi-channel sticky event capture for GPIO inputs.
- Per channel: synchroniser, debounce filter, selectable edge/level detector, sticky status bit with write-1-to-clear, and an overflow flag.
- Masked status is ORed into one registered interrupt.
- Sits between the GPIO pads and the software register file, driving status/overflow read-back and the CPU interrupt line.

Parameters:
- N_CH, 8, number of input channels.
- SYNC_STAGES, 2, synchroniser flop count per channel (>=2).
- DEB_W, 8, width of debounce counter and deb_len.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; one clock, synchronous, active-high.
- enable  input  1  capture enable; gates status/overflow updates only.
- sensor  input  N_CH  asynchronous raw inputs.
- mode  input  2*N_CH  per-channel detect mode, channel i at [2i+1:2i].
- deb_len  input  DEB_W  shared debounce length, in cycles minus one.
- clr  input  N_CH  one-cycle write-1-to-clear pulses for status/overflow.
- irq_mask  input  N_CH  1 = channel contributes to irq.
- level  output  N_CH  debounced input level.
- status  output  N_CH  sticky event flags.
- overflow  output  N_CH  event arrived while status already set.
- irq  output  1  registered OR of status & irq_mask.

Behaviour:
- Reset: all synchroniser flops, debounce counters, level, the previous-level register, status, overflow and irq are set to 0.
- Synchroniser: SYNC_STAGES flops, free-running, independent of enable.
- Debounce, per channel, on sync output s versus level L:
  - s==L: cnt<=0.
  - s!=L and cnt>=deb_len: L<=s, cnt<=0.
  - s!=L and cnt<deb_len: cnt<=cnt+1, saturating at all-ones.
  - deb_len is sampled live each cycle.
  - A mismatch shorter than deb_len+1 consecutive cycles produces no change.
- Detect: Lp <= L each cycle. Event is combinational from L and Lp:
  - mode 00: L (level-high).
  - mode 01: L&~Lp (rising).
  - mode 10: ~L&Lp (falling).
  - mode 11: L^Lp (both).
- Capture, only when enable=1:
  - status <= (status & ~clr) | ev.
  - overflow <= (overflow & ~clr) | (ev & status & ~clr).
  - Event simultaneous with clr: status stays/becomes 1 and overflow is not set (clear consumes the old event, the new one is kept).
  - enable=0: status/overflow hold, events are dropped, clr is ignored.
- irq <= |(status & irq_mask).
- Latency, counted from the first clk edge sampling sensor high:
  - level rises at edge SYNC_STAGES+1+deb_len.
  - status rises at edge SYNC_STAGES+2+deb_len.
  - irq rises one edge after status.
- Mode change takes effect on the next cycle's ev; no retroactive events.
- Mode 00 with input held high re-sets status every cycle: a clear lasts 0 cycles observably, and overflow sets on the cycle after the clear.
- Reset mid-operation discards in-flight debounce. A sensor held high through reset yields a rising event after the full latency.
- irq_mask change affects irq one cycle later; status itself is unaffected.

Decomposition:
- Shared header iob_gpio_event_def.vh: mode encodings GPIO_EV_LEVEL=2'b00, GPIO_EV_RISE=2'b01, GPIO_EV_FALL=2'b10, GPIO_EV_BOTH=2'b11.
- Sub-module iob_gpio_event_ch contains one channel: sync, debounce, detect, status, overflow.
- Top generates N_CH instances and registers the masked OR for irq.

Test Plan:
- Rise, mode 01, deb_len=0, mask=1, ch0: sensor 0->1 → level[0]=1 at edge 3, status[0]=1 at edge 4, irq=1 at edge 5, overflow[0]=0.
- Debounce, deb_len=3, mode 11, ch1: 3-cycle high glitch → level[1], status[1] stay 0. 6-cycle high pulse → level[1]=1 at edge 6, status[1]=1 at edge 7, and a falling event later leaves status[1]=1 and sets overflow[1]=1.
- Clear race, ch2: status[2]=1; clr[2]=1 on the same cycle as a new rising event → status[2]=1, overflow[2]=0. Next clr with no event → both 0, irq=0 two cycles later.
- Enable gating, ch3: enable=0, sensor pulses (deb_len=0) → level[3] toggles, status[3] stays 0. clr ignored while enable=0. Re-enable with sensor steady → no event.
- Mask and multi-channel: events on ch4 and ch5, irq_mask=8'h10 → irq=1. Clear ch4 → irq=0 one cycle after status[4] falls, status[5] still 1.
- Reset mid-debounce, deb_len=10: rst asserted at cnt=5 → all outputs 0 next edge. Sensor held high → status rises at edge 2+2+10=14 after rst release.

Source files
------------

// File: rtl/iob_gpio_event_latch_pkg.sv
// rtl/iob_gpio_event_latch_pkg.sv - detect-mode encodings and event decode shared by the event latch
//
// Purpose: one place for the per-channel detect-mode encoding and the function
//          that turns (mode, debounced level, previous level) into an event.
// Contents:
//   gpio_ev_mode_e  : 2-bit detect mode (level-high, rising, falling, both edges)
//   gpio_ev_detect  : combinational event decode used by every channel

package iob_gpio_event_latch_pkg;

    typedef enum logic [1:0] {
        GPIO_EV_LEVEL = 2'b00,
        GPIO_EV_RISE  = 2'b01,
        GPIO_EV_FALL  = 2'b10,
        GPIO_EV_BOTH  = 2'b11
    } gpio_ev_mode_e;

    function automatic logic gpio_ev_detect(
        input logic [1:0] mode,
        input logic       lvl,
        input logic       lvl_prev
    );
        logic ev;
        ev = 1'b0;
        case (gpio_ev_mode_e'(mode))
            GPIO_EV_LEVEL: ev = lvl;
            GPIO_EV_RISE:  ev = lvl & ~lvl_prev;
            GPIO_EV_FALL:  ev = ~lvl & lvl_prev;
            GPIO_EV_BOTH:  ev = lvl ^ lvl_prev;
            default:       ev = 1'b0;
        endcase
        return ev;
    endfunction

endpackage

// File: rtl/iob_gpio_event_ch.sv
// rtl/iob_gpio_event_ch.sv - one GPIO event channel: sync, debounce, detect, sticky status
//
// Purpose: capture events from one asynchronous GPIO input into a sticky,
//          write-1-to-clear status bit with an overflow flag.
// Ports:
//   i_clk, i_rst    : clock, synchronous active-high reset
//   i_enable        : gates status/overflow updates (sync/debounce keep running)
//   i_sensor        : raw asynchronous input
//   i_mode          : detect mode (see gpio_ev_mode_e)
//   i_deb_len       : debounce length in cycles minus one, sampled live
//   i_clr           : write-1-to-clear pulse for status and overflow
//   o_level         : debounced level
//   o_status        : sticky event flag
//   o_overflow      : event arrived while status was already set

module iob_gpio_event_ch
    import iob_gpio_event_latch_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_W       = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_enable,
    input  logic             i_sensor,
    input  logic [1:0]       i_mode,
    input  logic [DEB_W-1:0] i_deb_len,
    input  logic             i_clr,
    output logic             o_level,
    output logic             o_status,
    output logic             o_overflow
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [DEB_W-1:0]       r_cnt;
    logic                   r_level;
    logic                   r_level_prev;
    logic                   r_status;
    logic                   r_overflow;

    logic                   w_s;
    logic                   w_ev;

    assign w_s  = r_sync[SYNC_STAGES-1];
    assign w_ev = gpio_ev_detect(i_mode, r_level, r_level_prev);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_sensor};
        end
    end

    // r_cnt counts consecutive cycles the synchronised input has disagreed
    // with the debounced level; the level follows once that run exceeds deb_len.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else if (w_s == r_level) begin
            r_cnt <= '0;
        end else if (r_cnt >= i_deb_len) begin
            r_level <= w_s;
            r_cnt   <= '0;
        end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + DEB_W'(1);
        end
    end

    // A clear and a new event in the same cycle: the clear retires the old
    // event, the new one is kept in status and does not count as overflow.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_level_prev <= 1'b0;
            r_status     <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_level_prev <= r_level;
            if (i_enable) begin
                r_status   <= (r_status & ~i_clr) | w_ev;
                r_overflow <= (r_overflow & ~i_clr) | (w_ev & r_status & ~i_clr);
            end
        end
    end

    assign o_level    = r_level;
    assign o_status   = r_status;
    assign o_overflow = r_overflow;

endmodule

// File: rtl/iob_gpio_event_latch.sv
// rtl/iob_gpio_event_latch.sv - multi-channel sticky GPIO event latch with masked interrupt
//
// Purpose: N_CH event channels between GPIO pads and the register file; the
//          masked OR of all status bits drives one registered interrupt.
// Ports:
//   i_clk, i_rst    : clock, synchronous active-high reset
//   i_enable        : capture enable for status/overflow
//   i_sensor        : raw asynchronous inputs, one per channel
//   i_mode          : detect mode, channel i at [2i+1:2i]
//   i_deb_len       : shared debounce length in cycles minus one
//   i_clr           : write-1-to-clear pulses
//   i_irq_mask      : 1 = channel contributes to o_irq
//   o_level         : debounced levels
//   o_status        : sticky event flags
//   o_overflow      : overflow flags
//   o_irq           : registered OR of status & irq_mask

module iob_gpio_event_latch
    import iob_gpio_event_latch_pkg::*;
#(
    parameter int N_CH        = 8,
    parameter int SYNC_STAGES = 2,
    parameter int DEB_W       = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_enable,
    input  logic [N_CH-1:0]   i_sensor,
    input  logic [2*N_CH-1:0] i_mode,
    input  logic [DEB_W-1:0]  i_deb_len,
    input  logic [N_CH-1:0]   i_clr,
    input  logic [N_CH-1:0]   i_irq_mask,
    output logic [N_CH-1:0]   o_level,
    output logic [N_CH-1:0]   o_status,
    output logic [N_CH-1:0]   o_overflow,
    output logic              o_irq
);

    logic [N_CH-1:0] w_status;
    logic            r_irq;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        iob_gpio_event_ch #(
            .SYNC_STAGES (SYNC_STAGES),
            .DEB_W       (DEB_W)
        ) u_ch (
            .i_clk      (i_clk),
            .i_rst      (i_rst),
            .i_enable   (i_enable),
            .i_sensor   (i_sensor[g]),
            .i_mode     (i_mode[2*g+1:2*g]),
            .i_deb_len  (i_deb_len),
            .i_clr      (i_clr[g]),
            .o_level    (o_level[g]),
            .o_status   (w_status[g]),
            .o_overflow (o_overflow[g])
        );
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= |(w_status & i_irq_mask);
        end
    end

    assign o_status = w_status;
    assign o_irq    = r_irq;

endmodule

// File: tb/tb_iob_gpio_event_latch.sv
// tb/tb_iob_gpio_event_latch.sv - self-checking bench for iob_gpio_event_latch

module tb_iob_gpio_event_latch;

    localparam int N  = 8;
    localparam int SS = 2;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [N-1:0]  sensor;
    logic [2*N-1:0] mode;
    logic [DW-1:0] deb;
    logic [N-1:0]  clr;
    logic [N-1:0]  mask;
    logic [N-1:0]  level;
    logic [N-1:0]  status;
    logic [N-1:0]  overflow;
    logic          irq;

    always #5 clk = ~clk;

    iob_gpio_event_latch #(.N_CH(N), .SYNC_STAGES(SS), .DEB_W(DW)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_enable   (en),
        .i_sensor   (sensor),
        .i_mode     (mode),
        .i_deb_len  (deb),
        .i_clr      (clr),
        .i_irq_mask (mask),
        .o_level    (level),
        .o_status   (status),
        .o_overflow (overflow),
        .o_irq      (irq)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: actual=%h required=%h", nm, $time, act, exp);
        end
    endtask

    // Reference model: sensor samples delayed through a queue; the debounced
    // level follows the synchronised input once the last deb+1 samples all
    // disagree with it; events and sticky flags follow the textual rules.
    logic [N-1:0] sq[$];
    bit           wq[N][$];
    logic [N-1:0] m_lvl, m_lp, m_st, m_ov;
    logic         m_irq;

    function automatic void model_reset();
        sq.delete();
        for (int k = 0; k < SS; k++) sq.push_back('0);
        for (int c = 0; c < N; c++) wq[c].delete();
        m_lvl = '0; m_lp = '0; m_st = '0; m_ov = '0; m_irq = 1'b0;
    endfunction

    function automatic void model_edge();
        logic [N-1:0] s, nl, nst, nov;
        logic         nirq, ev, hit;
        int           sz;
        if (rst) begin
            model_reset();
            return;
        end
        s = sq.pop_front();
        sq.push_back(sensor);
        nirq = ((m_st & mask) != 0);
        nst = m_st; nov = m_ov;
        for (int c = 0; c < N; c++) begin
            case (mode[2*c +: 2])
                2'd0:    ev = m_lvl[c];
                2'd1:    ev = m_lvl[c] && !m_lp[c];
                2'd2:    ev = !m_lvl[c] && m_lp[c];
                default: ev = m_lvl[c] != m_lp[c];
            endcase
            if (en) begin
                if (clr[c]) begin
                    nst[c] = ev;
                    nov[c] = 1'b0;
                end else begin
                    nov[c] = m_ov[c] | (ev & m_st[c]);
                    nst[c] = m_st[c] | ev;
                end
            end
            wq[c].push_back(s[c]);
            if (wq[c].size() > 300) void'(wq[c].pop_front());
            sz  = wq[c].size();
            hit = (sz >= int'(deb) + 1);
            for (int k = 0; k <= int'(deb) && hit; k++)
                if (wq[c][sz-1-k] == m_lvl[c]) hit = 1'b0;
            nl[c] = hit ? s[c] : m_lvl[c];
        end
        m_lp = m_lvl; m_lvl = nl; m_st = nst; m_ov = nov; m_irq = nirq;
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("model_level", 32'(level), 32'(m_lvl));
        chk("model_status", 32'(status), 32'(m_st));
        chk("model_overflow", 32'(overflow), 32'(m_ov));
        chk("model_irq", 32'(irq), 32'(m_irq));
    endtask

    typedef struct {
        logic          rst, en;
        logic [N-1:0]  sen;
        logic [2*N-1:0] mode;
        logic [DW-1:0] deb;
        logic [N-1:0]  clr, mask;
        int            n;
        logic [N-1:0]  lv, st, ov;
        logic          irq;
    } vec_t;

    vec_t tbl[$];

    function automatic void v(input logic r, input logic e, input logic [7:0] sn,
                              input logic [15:0] md, input logic [7:0] db, input logic [7:0] cl,
                              input logic [7:0] mk, input int n, input logic [7:0] lv,
                              input logic [7:0] st, input logic [7:0] ov, input logic iq);
        vec_t t;
        t.rst = r; t.en = e; t.sen = sn; t.mode = md; t.deb = db; t.clr = cl; t.mask = mk;
        t.n = n; t.lv = lv; t.st = st; t.ov = ov; t.irq = iq;
        tbl.push_back(t);
    endfunction

    task automatic drive(input logic r, input logic e, input logic [7:0] sn, input logic [15:0] md,
                         input logic [7:0] db, input logic [7:0] cl, input logic [7:0] mk);
        rst = r; en = e; sensor = sn; mode = md; deb = db; clr = cl; mask = mk;
    endtask

    task automatic chk_out(input string nm, input logic [7:0] lv, input logic [7:0] st,
                           input logic [7:0] ov, input logic iq);
        chk({nm, ".level"}, 32'(level), 32'(lv));
        chk({nm, ".status"}, 32'(status), 32'(st));
        chk({nm, ".overflow"}, 32'(overflow), 32'(ov));
        chk({nm, ".irq"}, 32'(irq), 32'(iq));
    endtask

    initial begin
        model_reset();
        drive(1'b1, 1'b1, 8'h00, 16'h5555, 8'd0, 8'h00, 8'h00);

        //  rst en  sensor mode      deb  clr    mask   n   level  status ovf    irq
        v(1, 1, 8'h00, 16'h5555, 0, 8'h00, 8'h01, 2, 8'h00, 8'h00, 8'h00, 0);  // reset
        v(0, 1, 8'h01, 16'h5555, 0, 8'h00, 8'h01, 2, 8'h00, 8'h00, 8'h00, 0);  // rise ch0
        v(0, 1, 8'h01, 16'h5555, 0, 8'h00, 8'h01, 1, 8'h01, 8'h00, 8'h00, 0);  // edge 3
        v(0, 1, 8'h01, 16'h5555, 0, 8'h00, 8'h01, 1, 8'h01, 8'h01, 8'h00, 0);  // edge 4
        v(0, 1, 8'h01, 16'h5555, 0, 8'h00, 8'h01, 1, 8'h01, 8'h01, 8'h00, 1);  // edge 5
        v(0, 1, 8'h01, 16'h5555, 0, 8'h01, 8'h01, 1, 8'h01, 8'h00, 8'h00, 1);
        v(0, 1, 8'h01, 16'h5555, 0, 8'h00, 8'h01, 1, 8'h01, 8'h00, 8'h00, 0);
        v(0, 1, 8'h03, 16'h555D, 3, 8'h00, 8'h00, 3, 8'h01, 8'h00, 8'h00, 0);  // glitch ch1
        v(0, 1, 8'h01, 16'h555D, 3, 8'h00, 8'h00, 8, 8'h01, 8'h00, 8'h00, 0);
        v(0, 1, 8'h03, 16'h555D, 3, 8'h00, 8'h00, 5, 8'h01, 8'h00, 8'h00, 0);  // 6-cycle pulse
        v(0, 1, 8'h03, 16'h555D, 3, 8'h00, 8'h00, 1, 8'h03, 8'h00, 8'h00, 0);  // edge 6
        v(0, 1, 8'h01, 16'h555D, 3, 8'h00, 8'h00, 1, 8'h03, 8'h02, 8'h00, 0);  // edge 7
        v(0, 1, 8'h01, 16'h555D, 3, 8'h00, 8'h00, 4, 8'h03, 8'h02, 8'h00, 0);
        v(0, 1, 8'h01, 16'h555D, 3, 8'h00, 8'h00, 1, 8'h01, 8'h02, 8'h00, 0);  // falls
        v(0, 1, 8'h01, 16'h555D, 3, 8'h00, 8'h00, 1, 8'h01, 8'h02, 8'h02, 0);  // overflow
        v(0, 1, 8'h01, 16'h5555, 0, 8'h02, 8'h00, 1, 8'h01, 8'h00, 8'h00, 0);
        v(0, 1, 8'h05, 16'h5555, 0, 8'h00, 8'h00, 4, 8'h05, 8'h04, 8'h00, 0);  // clear race ch2
        v(0, 1, 8'h01, 16'h5555, 0, 8'h00, 8'h00, 3, 8'h01, 8'h04, 8'h00, 0);
        v(0, 1, 8'h05, 16'h5555, 0, 8'h00, 8'h00, 3, 8'h05, 8'h04, 8'h00, 0);
        v(0, 1, 8'h05, 16'h5555, 0, 8'h04, 8'hFF, 1, 8'h05, 8'h04, 8'h00, 1);  // clr + event
        v(0, 1, 8'h05, 16'h5555, 0, 8'h04, 8'hFF, 1, 8'h05, 8'h00, 8'h00, 1);
        v(0, 1, 8'h05, 16'h5555, 0, 8'h00, 8'hFF, 1, 8'h05, 8'h00, 8'h00, 0);
        v(0, 0, 8'h0D, 16'h5555, 0, 8'h00, 8'h00, 3, 8'h0D, 8'h00, 8'h00, 0);  // enable gating ch3
        v(0, 0, 8'h05, 16'h5555, 0, 8'h00, 8'h00, 3, 8'h05, 8'h00, 8'h00, 0);
        v(0, 0, 8'h0D, 16'h5555, 0, 8'h00, 8'h00, 4, 8'h0D, 8'h00, 8'h00, 0);
        v(0, 1, 8'h0D, 16'h5555, 0, 8'h00, 8'h00, 2, 8'h0D, 8'h00, 8'h00, 0);  // re-enable steady
        v(0, 1, 8'h05, 16'h5555, 0, 8'h00, 8'h00, 3, 8'h05, 8'h00, 8'h00, 0);
        v(0, 1, 8'h0D, 16'h5555, 0, 8'h00, 8'h00, 4, 8'h0D, 8'h08, 8'h00, 0);
        v(0, 0, 8'h0D, 16'h5555, 0, 8'h08, 8'h00, 1, 8'h0D, 8'h08, 8'h00, 0);  // clr ignored
        v(0, 0, 8'h0D, 16'h5555, 0, 8'h00, 8'h00, 1, 8'h0D, 8'h08, 8'h00, 0);
        v(0, 1, 8'h0D, 16'h5555, 0, 8'h08, 8'h00, 1, 8'h0D, 8'h00, 8'h00, 0);
        v(0, 1, 8'h3D, 16'h5555, 0, 8'h00, 8'h10, 4, 8'h3D, 8'h30, 8'h00, 0);  // mask ch4/ch5
        v(0, 1, 8'h3D, 16'h5555, 0, 8'h00, 8'h10, 1, 8'h3D, 8'h30, 8'h00, 1);
        v(0, 1, 8'h3D, 16'h5555, 0, 8'h10, 8'h10, 1, 8'h3D, 8'h20, 8'h00, 1);
        v(0, 1, 8'h3D, 16'h5555, 0, 8'h00, 8'h10, 1, 8'h3D, 8'h20, 8'h00, 0);
        v(0, 1, 8'h3D, 16'h5555, 0, 8'hFF, 8'h10, 1, 8'h3D, 8'h00, 8'h00, 0);
        v(0, 1, 8'h7D, 16'h5555, 10, 8'h00, 8'h10, 7, 8'h3D, 8'h00, 8'h00, 0); // mid-debounce
        v(1, 1, 8'h7D, 16'h5555, 10, 8'h00, 8'h10, 1, 8'h00, 8'h00, 8'h00, 0); // reset
        v(0, 1, 8'h7D, 16'h5555, 10, 8'h00, 8'h10, 12, 8'h00, 8'h00, 8'h00, 0);
        v(0, 1, 8'h7D, 16'h5555, 10, 8'h00, 8'h10, 1, 8'h7D, 8'h00, 8'h00, 0); // edge 13
        v(0, 1, 8'h7D, 16'h5555, 10, 8'h00, 8'h10, 1, 8'h7D, 8'h7D, 8'h00, 0); // edge 14
        v(0, 1, 8'h7D, 16'h5555, 10, 8'h00, 8'h10, 1, 8'h7D, 8'h7D, 8'h00, 1);

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].en, tbl[i].sen, tbl[i].mode, tbl[i].deb, tbl[i].clr, tbl[i].mask);
            for (int k = 0; k < tbl[i].n; k++) step();
            chk_out($sformatf("row%0d", i), tbl[i].lv, tbl[i].st, tbl[i].ov, tbl[i].irq);
        end

        // Level mode with inputs held high: a clear is invisible on status
        // and overflow comes back the following cycle.
        drive(1'b0, 1'b1, 8'h7D, 16'h0000, 8'd10, 8'h00, 8'h00);
        step();
        chk_out("lvl_hold", 8'h7D, 8'h7D, 8'h7D, 1'b0);
        clr = 8'hFF;
        step();
        chk_out("lvl_clr", 8'h7D, 8'h7D, 8'h00, 1'b0);
        clr = 8'h00;
        step();
        chk_out("lvl_after", 8'h7D, 8'h7D, 8'h7D, 1'b0);
        mask = 8'h80;
        step();
        chk_out("mask_80", 8'h7D, 8'h7D, 8'h7D, 1'b0);
        mask = 8'h01;
        step();
        chk_out("mask_01", 8'h7D, 8'h7D, 8'h7D, 1'b1);

        // Randomised run checked against the reference model every cycle.
        for (int seg = 0; seg < 40; seg++) begin
            mode = 16'($urandom);
            deb  = 8'($urandom_range(0, 4));
            mask = 8'($urandom);
            for (int cyc = 0; cyc < 60; cyc++) begin
                for (int c = 0; c < N; c++)
                    if ($urandom_range(0, 5) == 0) sensor[c] = ~sensor[c];
                clr = 8'($urandom & $urandom & $urandom);
                en  = ($urandom_range(0, 15) != 0);
                rst = ($urandom_range(0, 499) == 0);
                step();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
